// File: rtl/wide_alu_pkg.sv
// -----------------------------------------------------------------------------
// wide_alu_pkg
// Shared types and constants for the byte-serial wide ALU sequencer.
//   state_e            : sequencer FSM states (IDLE, RUN, DONE)
//   OP_AND/OR/ADD/SUB  : Operation encodings seen on the request bus
//   DEFAULT_NUM_BYTES  : default operand width in bytes
// -----------------------------------------------------------------------------
package wide_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] OP_AND = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_ADD = 2'd2;
   localparam logic [1:0] OP_SUB = 2'd3;

   localparam int DEFAULT_NUM_BYTES = 4;

endpackage

// File: rtl/wide_alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// wide_alu_sequencer_if
// Request/response bus of the wide ALU sequencer.
//   Request : in_valid, in_ready, a, b, CarryIn, Operation
//   Response: out_valid, out_ready, Result, CarryOut
//   master  : the requester/consumer side
//   slave   : the sequencer side
// -----------------------------------------------------------------------------
interface wide_alu_sequencer_if
   import wide_alu_pkg::*;
#(
   parameter int NUM_BYTES = DEFAULT_NUM_BYTES
);
   logic                   in_valid;
   logic                   in_ready;
   logic [8*NUM_BYTES-1:0] a;
   logic [8*NUM_BYTES-1:0] b;
   logic                   CarryIn;
   logic [1:0]             Operation;
   logic                   out_valid;
   logic                   out_ready;
   logic [8*NUM_BYTES-1:0] Result;
   logic                   CarryOut;

   modport master (
      output in_valid, a, b, CarryIn, Operation, out_ready,
      input  in_ready, out_valid, Result, CarryOut
   );

   modport slave (
      input  in_valid, a, b, CarryIn, Operation, out_ready,
      output in_ready, out_valid, Result, CarryOut
   );

endinterface

// File: rtl/eight_bit_ALU.sv
// -----------------------------------------------------------------------------
// eight_bit_ALU
// Combinational 8-bit ALU slice.
//   A, B      : operand bytes
//   Operation : OP_AND, OP_OR, OP_ADD; any other code yields zero
//   CarryIn   : carry into bit 0 (ADD only)
//   Result    : result byte
//   CarryOut  : carry out of bit 7 (ADD only, otherwise 0)
// -----------------------------------------------------------------------------
module eight_bit_ALU
   import wide_alu_pkg::*;
(
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [1:0] Operation,
   input  logic       CarryIn,
   output logic [7:0] Result,
   output logic       CarryOut
);

   logic [8:0] sum_s;

   // Slice arithmetic/logic selection.
   always_comb begin
      sum_s    = {1'b0, A} + {1'b0, B} + {8'd0, CarryIn};
      Result   = 8'd0;
      CarryOut = 1'b0;
      case (Operation)
         OP_AND: Result = A & B;
         OP_OR:  Result = A | B;
         OP_ADD: begin
            Result   = sum_s[7:0];
            CarryOut = sum_s[8];
         end
         default: begin
            Result   = 8'd0;
            CarryOut = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/wide_alu_sequencer.sv
// -----------------------------------------------------------------------------
// wide_alu_sequencer
// Runs AND / OR / ADD-with-carry on W = 8*NUM_BYTES bit operands by stepping
// one eight_bit_ALU across the bytes, low byte first, one byte per clock.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : wide_alu_sequencer_if.slave (request a/b/CarryIn/Operation with
//            in_valid/in_ready; response Result/CarryOut with
//            out_valid/out_ready)
// Optional feature macro: WIDE_ALU_SUB_EN -- Operation 3 performs A-B
// (inverted B bytes, forced carry-in of 1). Without it Operation 3 returns
// Result=0, CarryOut=0 after the usual number of cycles.
// -----------------------------------------------------------------------------
module wide_alu_sequencer
   import wide_alu_pkg::*;
#(
   parameter int NUM_BYTES = DEFAULT_NUM_BYTES
)
(
   input  logic                clk,
   input  logic                rst_n,
   wide_alu_sequencer_if.slave bus
);

   localparam int W  = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES);
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

   state_e          state_r, next_state_s;
   logic [W-1:0]    a_r, b_r, acc_r, acc_next_s, result_r;
   logic            cin_r, carry_r, cout_r;
   logic [1:0]      op_r;
   logic [CW-1:0]   cnt_r;
   logic            last_s, arith_s;
   logic [7:0]      alu_a_s, alu_b_s, alu_res_s;
   logic [1:0]      alu_op_s;
   logic            alu_cin_s, alu_cout_s;

   assign bus.in_ready  = (state_r == IDLE);
   assign bus.out_valid = (state_r == DONE);
   assign bus.Result    = result_r;
   assign bus.CarryOut  = cout_r;

   assign last_s = (cnt_r == LAST_IDX);

   // Only arithmetic operations report a carry out of the top byte.
`ifdef WIDE_ALU_SUB_EN
   assign arith_s = (op_r == OP_ADD) || (op_r == OP_SUB);
`else
   assign arith_s = (op_r == OP_ADD);
`endif

   // Operand byte selection and carry-in chaining for the current byte.
   always_comb begin
      alu_a_s = a_r[{cnt_r, 3'b000} +: 8];
      alu_b_s = b_r[{cnt_r, 3'b000} +: 8];
      alu_op_s = op_r;
      if (cnt_r == {CW{1'b0}}) begin
         alu_cin_s = cin_r;
      end else begin
         alu_cin_s = carry_r;
      end
`ifdef WIDE_ALU_SUB_EN
      // A-B computed as A + ~B + 1 across the whole word.
      if (op_r == OP_SUB) begin
         alu_b_s  = ~b_r[{cnt_r, 3'b000} +: 8];
         alu_op_s = OP_ADD;
         if (cnt_r == {CW{1'b0}}) begin
            alu_cin_s = 1'b1;
         end else begin
            alu_cin_s = carry_r;
         end
      end else begin
         alu_op_s = op_r;
      end
`endif
   end

   // Accumulator with the current ALU byte merged in; used for the final word.
   always_comb begin
      acc_next_s = acc_r;
      acc_next_s[{cnt_r, 3'b000} +: 8] = alu_res_s;
   end

   eight_bit_ALU u_alu (
      .A         (alu_a_s),
      .B         (alu_b_s),
      .Operation (alu_op_s),
      .CarryIn   (alu_cin_s),
      .Result    (alu_res_s),
      .CarryOut  (alu_cout_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) next_state_s = RUN;
            else              next_state_s = IDLE;
         end
         RUN: begin
            if (last_s) next_state_s = DONE;
            else        next_state_s = RUN;
         end
         DONE: begin
            if (bus.out_ready) next_state_s = IDLE;
            else               next_state_s = DONE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Operand capture, byte-serial accumulation and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= {W{1'b0}};
         b_r      <= {W{1'b0}};
         cin_r    <= 1'b0;
         op_r     <= 2'd0;
         cnt_r    <= {CW{1'b0}};
         carry_r  <= 1'b0;
         acc_r    <= {W{1'b0}};
         result_r <= {W{1'b0}};
         cout_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  cin_r   <= bus.CarryIn;
                  op_r    <= bus.Operation;
                  cnt_r   <= {CW{1'b0}};
                  carry_r <= 1'b0;
               end
            end
            RUN: begin
               acc_r   <= acc_next_s;
               carry_r <= alu_cout_s;
               if (last_s) begin
                  cnt_r    <= {CW{1'b0}};
                  result_r <= acc_next_s;
                  cout_r   <= arith_s ? alu_cout_s : 1'b0;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wide_alu_sequencer
// Directed self-checking bench for wide_alu_sequencer at NUM_BYTES=4.
// Expected Operation-3 results follow WIDE_ALU_SUB_EN.
// -----------------------------------------------------------------------------
module tb_wide_alu_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   wide_alu_sequencer_if #(.NUM_BYTES(4)) bus ();

   wide_alu_sequencer #(.NUM_BYTES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request and let it be accepted; then scramble the inputs.
   task automatic start_op(input logic [1:0] op, input logic [31:0] av,
                           input logic [31:0] bv, input logic cin);
      @(negedge clk);
      check("in_ready_idle", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.a         = av;
      bus.b         = bv;
      bus.CarryIn   = cin;
      bus.Operation = op;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.a         = 32'hDEADBEEF;
      bus.b         = 32'h5A5A5A5A;
      bus.CarryIn   = ~cin;
      bus.Operation = op ^ 2'b01;
   endtask

   // Count edges from accept until out_valid, bounded.
   task automatic wait_out(input string tag);
      int cycles;
      cycles = 0;
      while (!bus.out_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check({tag, "_latency"}, cycles, 4);
   endtask

   task automatic finish_op();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("out_valid_after_hs", bus.out_valid, 0);
      check("in_ready_after_hs", bus.in_ready, 1);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic cin,
                         input logic [31:0] exp_res, input logic exp_co);
      start_op(op, av, bv, cin);
      wait_out(tag);
      check({tag, "_result"}, bus.Result, exp_res);
      check({tag, "_carry"}, bus.CarryOut, exp_co);
      finish_op();
   endtask

   initial begin
      logic [31:0] held_res;
      logic        held_co;
      checks = 0;
      errors = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = 32'h0;
      bus.b         = 32'h0;
      bus.CarryIn   = 1'b0;
      bus.Operation = 2'd0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_result", bus.Result, 0);
      check("rst_carry", bus.CarryOut, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_ff_1", 2'd2, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
      run_op("add_ripple", 2'd2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
      run_op("and", 2'd0, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'h00F01200, 1'b0);
      run_op("or", 2'd1, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'hFFF0FF34, 1'b0);
      run_op("add_mid", 2'd2, 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0);
      run_op("add_top", 2'd2, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
`ifdef WIDE_ALU_SUB_EN
      run_op("op3", 2'd3, 32'h00000005, 32'h00000006, 1'b0, 32'hFFFFFFFF, 1'b0);
      run_op("sub_nb", 2'd3, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b1);
`else
      run_op("op3", 2'd3, 32'h00000005, 32'h00000006, 1'b1, 32'h00000000, 1'b0);
`endif

      // Backpressure: result held, requests ignored while DONE.
      start_op(2'd2, 32'h12345678, 32'h11111111, 1'b0);
      wait_out("bp");
      held_res = 32'h23456789;
      held_co  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid  = 1'b1;
         bus.a         = 32'h0000FFFF;
         bus.b         = 32'h00000001;
         bus.Operation = 2'd2;
         @(posedge clk);
         #1;
         check("bp_result", bus.Result, held_res);
         check("bp_carry", bus.CarryOut, held_co);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_out_valid", bus.out_valid, 1);
      end
      // in_valid stays high across the handshake edge and must not be taken.
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("bp_release_out_valid", bus.out_valid, 0);
      check("bp_release_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      check("bp_no_accept", bus.in_ready, 1);

      // out_ready held high in advance: DONE lasts one cycle.
      bus.out_ready = 1'b1;
      start_op(2'd1, 32'h0000000F, 32'h000000F0, 1'b0);
      wait_out("early_rdy");
      check("early_rdy_result", bus.Result, 32'h000000FF);
      @(posedge clk);
      #1;
      check("early_rdy_one_cycle", bus.out_valid, 0);
      check("early_rdy_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b0;

      // Reset while byte 2 is being computed.
      start_op(2'd2, 32'h10101010, 32'h20202020, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_result", bus.Result, 0);
      check("midrst_carry", bus.CarryOut, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_still_idle", bus.out_valid, 0);
      run_op("post_rst_add", 2'd2, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
